// File: rtl/brk_arb.sv
// Data-break arbiter/sequencer: steals memory cycles between CPU major states,
// grants break devices by fixed priority and runs read/write/incr/add cycles.
module brk_arb #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 cpu_yield,
    input  logic [NREQ-1:0]      brk_rq,
    input  logic [15*NREQ-1:0]   brk_addr,
    input  logic [12*NREQ-1:0]   brk_wdata,
    input  logic [2*NREQ-1:0]    brk_mode,
    input  logic [0:11]          mem_rdata,
    output logic                 cpu_hold,
    output logic [NREQ-1:0]      brk_gnt,
    output logic                 brk_ack,
    output logic [0:11]          brk_rdata,
    output logic                 brk_ovf,
    output logic [0:14]          mem_addr,
    output logic [0:11]          mem_wdata,
    output logic                 mem_we,
    output logic [2:0]           dbg_state_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BURST = BW'(MAX_BURST - 1);

    localparam logic [1:0] MODE_RD  = 2'b00;
    localparam logic [1:0] MODE_WR  = 2'b01;
    localparam logic [1:0] MODE_INC = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   burst_q;
    logic [0:14]     addr_q;
    logic [0:11]     wdata_q;
    logic [1:0]      mode_q;
    logic [NREQ-1:0] gnt_q;
    logic            hold_q;
    logic            ack_q;
    logic [0:11]     rdata_q;
    logic            ovf_q;
    logic [0:14]     maddr_q;
    logic [0:11]     mwdata_q;
    logic            we_q;

    logic [NREQ-1:0] req_m;
    logic            pick_any;
    logic [NREQ-1:0] pick_oh;
    logic [0:14]     pick_addr;
    logic [0:11]     pick_wdata;
    logic [1:0]      pick_mode;
    logic [0:12]     sum_d;

    // Served device is masked during DONE; gnt_q is zero in IDLE so no mask applies there.
    always_comb begin
        req_m      = brk_rq & ~gnt_q;
        pick_any   = 1'b0;
        pick_oh    = '0;
        pick_addr  = '0;
        pick_wdata = '0;
        pick_mode  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_m[i]) begin
                pick_any    = 1'b1;
                pick_oh     = '0;
                pick_oh[i]  = 1'b1;
                pick_addr   = brk_addr[15*i +: 15];
                pick_wdata  = brk_wdata[12*i +: 12];
                pick_mode   = brk_mode[2*i +: 2];
            end
        end
    end

    // Bit 0 of the 13-bit sum is the carry out of the 12-bit word.
    always_comb begin
        sum_d = {1'b0, mem_rdata} + ((mode_q == MODE_INC) ? 13'd1 : {1'b0, wdata_q});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            burst_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mode_q   <= '0;
            gnt_q    <= '0;
            hold_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            we_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
            we_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_yield && pick_any && !clear) begin
                        addr_q  <= pick_addr;
                        wdata_q <= pick_wdata;
                        mode_q  <= pick_mode;
                        gnt_q   <= pick_oh;
                        hold_q  <= 1'b1;
                        maddr_q <= pick_addr;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (mode_q == MODE_WR) begin
                        we_q     <= 1'b1;
                        mwdata_q <= wdata_q;
                        state_q  <= S_WRITE;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    rdata_q <= mem_rdata;
                    if (mode_q == MODE_RD) begin
                        maddr_q <= '0;
                        ack_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        we_q     <= 1'b1;
                        mwdata_q <= sum_d[1:12];
                        ovf_q    <= sum_d[0];
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    maddr_q  <= '0;
                    mwdata_q <= '0;
                    ack_q    <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    // Burst continues only while under the limit; otherwise the CPU gets a cycle.
                    if (!clear && pick_any && (burst_q < LAST_BURST)) begin
                        burst_q <= burst_q + BW'(1);
                        addr_q  <= pick_addr;
                        wdata_q <= pick_wdata;
                        mode_q  <= pick_mode;
                        gnt_q   <= pick_oh;
                        maddr_q <= pick_addr;
                        state_q <= S_ADDR;
                    end else begin
                        hold_q  <= 1'b0;
                        burst_q <= '0;
                        gnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_hold    = hold_q;
    assign brk_gnt     = gnt_q;
    assign brk_ack     = ack_q;
    assign brk_rdata   = rdata_q;
    assign brk_ovf     = ovf_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = mwdata_q;
    assign mem_we      = we_q;
    assign dbg_state_o = state_q;

endmodule
